// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU with its iterative multiply/divide
// unit: the 5-bit operation codes, the MD unit state encoding, the value
// used to fill LO on a divide by zero, and small op-classification helpers.
// No ports; imported by alu_md and alu_md_unit.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [4:0] ALU_NOP   = 5'h00;
  localparam logic [4:0] ALU_ADD   = 5'h01;
  localparam logic [4:0] ALU_SUB   = 5'h02;
  localparam logic [4:0] ALU_AND   = 5'h03;
  localparam logic [4:0] ALU_OR    = 5'h04;
  localparam logic [4:0] ALU_SLT   = 5'h05;
  localparam logic [4:0] ALU_SLTU  = 5'h06;
  localparam logic [4:0] ALU_NOR   = 5'h07;
  localparam logic [4:0] ALU_LUI   = 5'h08;
  localparam logic [4:0] ALU_SLL   = 5'h09;
  localparam logic [4:0] ALU_SRL   = 5'h0A;
  localparam logic [4:0] ALU_SRA   = 5'h0B;
  localparam logic [4:0] ALU_XOR   = 5'h0C;
  localparam logic [4:0] ALU_MULT  = 5'h10;
  localparam logic [4:0] ALU_MULTU = 5'h11;
  localparam logic [4:0] ALU_DIV   = 5'h12;
  localparam logic [4:0] ALU_DIVU  = 5'h13;
  localparam logic [4:0] ALU_MFHI  = 5'h14;
  localparam logic [4:0] ALU_MFLO  = 5'h15;
  localparam logic [4:0] ALU_MTHI  = 5'h16;
  localparam logic [4:0] ALU_MTLO  = 5'h17;

  // A divide by zero leaves LO filled with this bit (all ones) and copies
  // the original dividend into HI; no exception is raised.
  localparam logic DIVZ_LO_FILL = 1'b1;

  // MD unit sequencing: idle, WIDTH shift/add or shift/subtract steps,
  // then one final step that applies the sign fix and writes HI/LO.
  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FINISH
  } md_state_e;

  // True for the ops that start a multi-cycle multiply or divide.
  function automatic logic is_md_op(input logic [4:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) ||
           (op == ALU_DIV)  || (op == ALU_DIVU);
  endfunction

  // True for every op that needs the MD unit or its HI/LO registers, and
  // therefore has to wait while the unit is iterating.
  function automatic logic uses_md_unit(input logic [4:0] op);
    return (op >= ALU_MULT) && (op <= ALU_MTLO);
  endfunction

endpackage

// File: rtl/alu_md_unit.sv
// ---------------------------------------------------------------------------
// alu_md_unit
// Iterative multiply/divide unit with HI/LO registers. A multiply is a
// radix-2 shift-and-add over operand magnitudes; a divide is a restoring
// radix-2 divide over magnitudes. The sign is applied in the final step.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   start            latch op/a/b and begin iterating (only sampled when idle)
//   op               ALU op code (MULT, MULTU, DIV, DIVU)
//   a, b             multiplicand/multiplier or dividend/divisor
//   mt_hi, mt_lo     load HI / LO from mt_data (only sampled when idle)
//   mt_data          value for MTHI/MTLO
//   busy             unit is iterating
//   hi, lo           architectural HI/LO registers
// ---------------------------------------------------------------------------
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  md_state_e          r_state;
  md_state_e          w_nextState;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH-1:0]   r_accHi;
  logic [WIDTH-1:0]   r_accLo;
  logic [WIDTH-1:0]   r_opB;
  logic [WIDTH-1:0]   r_origA;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_isDiv;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_divZero;

  logic               w_isSigned;
  logic               w_isDivOp;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shifted;
  logic               w_fits;
  logic [WIDTH-1:0]   w_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quotFix;
  logic [WIDTH-1:0]   w_remFix;

  // Operand preparation at issue: signed ops iterate on magnitudes. The
  // most-negative value maps onto itself, which read as unsigned is the
  // correct magnitude 2^(WIDTH-1).
  assign w_isSigned = (op == ALU_MULT) || (op == ALU_DIV);
  assign w_isDivOp  = (op == ALU_DIV)  || (op == ALU_DIVU);
  assign w_magA     = (w_isSigned && a[WIDTH-1]) ? -a : a;
  assign w_magB     = (w_isSigned && b[WIDTH-1]) ? -b : b;

  // One multiply step: conditionally add the multiplicand into the upper
  // half, then shift the whole {carry, accHi, accLo} right by one. The
  // multiplier bits are consumed from the bottom of accLo.
  assign w_addend = r_accLo[0] ? r_opB : '0;
  assign w_sum    = {1'b0, r_accHi} + {1'b0, w_addend};

  // One restoring divide step: shift the partial remainder left, pulling in
  // the next dividend bit, and subtract the divisor if it fits. The shifted
  // value needs one extra bit; the subtraction result always fits WIDTH bits
  // because it is only kept when it is smaller than the divisor.
  assign w_shifted = {r_accHi, r_accLo[WIDTH-1]};
  assign w_fits    = (w_shifted >= {1'b0, r_opB});
  assign w_trial   = w_shifted[WIDTH-1:0] - r_opB;

  // Final sign fix: product sign is the XOR of operand signs, the quotient
  // likewise, and the remainder follows the dividend.
  assign w_prod    = {r_accHi, r_accLo};
  assign w_prodFix = r_negRes ? -w_prod : w_prod;
  assign w_quotFix = r_negRes ? -r_accLo : r_accLo;
  assign w_remFix  = r_negRem ? -r_accHi : r_accHi;

  // State register of the sequencing FSM.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: WIDTH iteration steps, then a single finish step.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      MD_IDLE: begin
        if (start) begin
          w_nextState = MD_RUN;
        end
      end
      MD_RUN: begin
        if (r_cnt == LAST_ITER) begin
          w_nextState = MD_FINISH;
        end
      end
      MD_FINISH: begin
        w_nextState = MD_IDLE;
      end
      default: begin
        w_nextState = MD_IDLE;
      end
    endcase
  end

  // Datapath: latch operands at issue, iterate, then commit HI/LO. HI/LO
  // only change on the finish step or on a move-to when idle, so a reset
  // mid-operation discards the partial result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_opB     <= '0;
      r_origA   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            r_cnt     <= '0;
            r_accHi   <= '0;
            r_accLo   <= w_magA;
            r_opB     <= w_magB;
            r_origA   <= a;
            r_isDiv   <= w_isDivOp;
            r_negRes  <= w_isSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_negRem  <= w_isSigned && a[WIDTH-1];
            r_divZero <= w_isDivOp && (b == '0);
          end else begin
            if (mt_hi) begin
              r_hi <= mt_data;
            end
            if (mt_lo) begin
              r_lo <= mt_data;
            end
          end
        end
        MD_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_isDiv) begin
            r_accHi <= w_fits ? w_trial : w_shifted[WIDTH-1:0];
            r_accLo <= {r_accLo[WIDTH-2:0], w_fits};
          end else begin
            r_accHi <= w_sum[WIDTH:1];
            r_accLo <= {w_sum[0], r_accLo[WIDTH-1:1]};
          end
        end
        MD_FINISH: begin
          r_cnt <= '0;
          if (r_isDiv) begin
            if (r_divZero) begin
              r_lo <= {WIDTH{DIVZ_LO_FILL}};
              r_hi <= r_origA;
            end else begin
              r_lo <= w_quotFix;
              r_hi <= w_remFix;
            end
          end else begin
            r_lo <= w_prodFix[WIDTH-1:0];
            r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = (r_state != MD_IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: rtl/alu_md.sv
// ---------------------------------------------------------------------------
// alu_md
// EX-stage ALU: single-cycle integer ops computed combinationally on C, plus
// an iterative multiply/divide unit with HI/LO. Stall freezes the front of
// the pipeline while an op that needs the MD unit waits for it.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   A, B        operands (A[SHW-1:0] is the shift amount for shifts)
//   ALUOp       5-bit op code (see alu_pkg)
//   OpValid     EX stage holds a real instruction
//   C           result (combinational)
//   Zero        C == 0
//   Overflow    signed overflow on ADD/SUB, else 0
//   Busy        MD unit is iterating
//   Stall       the current op cannot complete this cycle
// ---------------------------------------------------------------------------
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALUOp,
  input  logic             OpValid,
  output logic [WIDTH-1:0] C,
  output logic             Zero,
  output logic             Overflow,
  output logic             Busy,
  output logic             Stall
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_addOvf;
  logic             w_subOvf;
  logic             w_busy;
  logic             w_issueOk;
  logic             w_start;
  logic             w_mtHi;
  logic             w_mtLo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;

  // Adder/subtractor shared by the result mux and the overflow detect.
  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the
  // result sign differs from A.
  assign w_shamt  = A[SHW-1:0];
  assign w_sum    = A + B;
  assign w_diff   = A - B;
  assign w_addOvf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1]  != A[WIDTH-1]);
  assign w_subOvf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);

  // Anything touching the MD unit is accepted only while it is idle; an op
  // that is stalled is neither issued nor allowed to write HI/LO. Non-MD ops
  // complete regardless of Busy so independent work overlaps the iteration.
  assign w_issueOk = OpValid && !w_busy;
  assign w_start   = w_issueOk && is_md_op(ALUOp);
  assign w_mtHi    = w_issueOk && (ALUOp == ALU_MTHI);
  assign w_mtLo    = w_issueOk && (ALUOp == ALU_MTLO);
  assign Stall     = OpValid && w_busy && uses_md_unit(ALUOp);

  alu_md_unit #(
    .WIDTH (WIDTH)
  ) u_md (
    .clk     (clk),
    .rstn    (rstn),
    .start   (w_start),
    .op      (ALUOp),
    .a       (A),
    .b       (B),
    .mt_hi   (w_mtHi),
    .mt_lo   (w_mtLo),
    .mt_data (A),
    .busy    (w_busy),
    .hi      (w_hi),
    .lo      (w_lo)
  );

  // Result mux. Unknown op codes fall through to the NOP behaviour (C = A);
  // MD issue and move-to ops also pass A through.
  always_comb begin
    w_result = A;
    w_ovf    = 1'b0;
    case (ALUOp)
      ALU_NOP:   w_result = A;
      ALU_ADD: begin
        w_result = w_sum;
        w_ovf    = w_addOvf;
      end
      ALU_SUB: begin
        w_result = w_diff;
        w_ovf    = w_subOvf;
      end
      ALU_AND:   w_result = A & B;
      ALU_OR:    w_result = A | B;
      ALU_SLT:   w_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU:  w_result = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_NOR:   w_result = ~(A | B);
      ALU_LUI:   w_result = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_SLL:   w_result = B << w_shamt;
      ALU_SRL:   w_result = B >> w_shamt;
      ALU_SRA:   w_result = $signed(B) >>> w_shamt;
      ALU_XOR:   w_result = A ^ B;
      ALU_MULT:  w_result = A;
      ALU_MULTU: w_result = A;
      ALU_DIV:   w_result = A;
      ALU_DIVU:  w_result = A;
      ALU_MFHI:  w_result = w_hi;
      ALU_MFLO:  w_result = w_lo;
      ALU_MTHI:  w_result = A;
      ALU_MTLO:  w_result = A;
      default:   w_result = A;
    endcase
  end

  assign C        = w_result;
  assign Zero     = (w_result == '0);
  assign Overflow = w_ovf;
  assign Busy     = w_busy;

endmodule

// File: tb/tb_alu_md.sv
// ---------------------------------------------------------------------------
// tb_alu_md
// Scoreboard bench for alu_md. The stimulus side drives one instruction per
// cycle, works out the expected response from a plain-arithmetic reference
// model of the ALU and HI/LO, and queues it; a monitor on the falling edge
// pops and compares. A second, 16-bit instance gets a short directed check.
// ---------------------------------------------------------------------------
module tb_alu_md;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] A, B, C;
  logic [4:0]  ALUOp;
  logic        OpValid, Zero, Overflow, Busy, Stall;

  logic [15:0] A16, B16, C16;
  logic [4:0]  Op16;
  logic        V16, Zero16, Overflow16, Busy16, Stall16;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic        valid;
    logic [4:0]  op;
    logic [31:0] c;
    logic        zero;
    logic        ovf;
    logic        busy;
    logic        stall;
  } exp_t;

  exp_t expQ[$];
  logic monActive = 1'b0;

  logic [31:0] mHi, mLo, pendHi, pendLo;
  int          busyLeft;

  logic [4:0] badOps [5] = '{5'h0D, 5'h0E, 5'h0F, 5'h18, 5'h1F};

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .A(A), .B(B), .ALUOp(ALUOp), .OpValid(OpValid),
    .C(C), .Zero(Zero), .Overflow(Overflow), .Busy(Busy), .Stall(Stall)
  );

  alu_md #(.WIDTH(16)) dut16 (
    .clk(clk), .rstn(rstn), .A(A16), .B(B16), .ALUOp(Op16), .OpValid(V16),
    .C(C16), .Zero(Zero16), .Overflow(Overflow16), .Busy(Busy16), .Stall(Stall16)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model of the single-cycle result, straight from the op table.
  function automatic void modelAlu(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] c,
                                   output logic ovf);
    longint sa, sb, s;
    longint sMax, sMin;
    int     sh;
    sMax = 64'sd2147483647;
    sMin = -sMax - 1;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sh   = int'(a % 32);
    c    = a;
    ovf  = 1'b0;
    case (op)
      5'h01: begin s = sa + sb; c = 32'(s); ovf = (s > sMax) || (s < sMin); end
      5'h02: begin s = sa - sb; c = 32'(s); ovf = (s > sMax) || (s < sMin); end
      5'h03: c = a & b;
      5'h04: c = a | b;
      5'h05: c = (sa < sb) ? 32'd1 : 32'd0;
      5'h06: c = (a < b) ? 32'd1 : 32'd0;
      5'h07: c = ~(a | b);
      5'h08: c = (b & 32'h0000FFFF) << 16;
      5'h09: c = b << sh;
      5'h0A: c = b >> sh;
      5'h0B: c = 32'(sb >>> sh);
      5'h0C: c = a ^ b;
      5'h14: c = mHi;
      5'h15: c = mLo;
      default: c = a;
    endcase
  endfunction

  // Reference model of what happens at a clock edge: an in-flight MD op
  // counts down and commits its whole result when it ends; an accepted op
  // starts a new MD operation or moves A into HI/LO.
  function automatic void modelEdge(input logic accepted, input logic [4:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) begin
        mHi = pendHi;
        mLo = pendLo;
      end
    end else if (accepted) begin
      case (op)
        5'h10: begin
          p = sa * sb; pendHi = p[63:32]; pendLo = p[31:0]; busyLeft = W + 1;
        end
        5'h11: begin
          pu = {32'b0, a} * {32'b0, b}; pendHi = pu[63:32]; pendLo = pu[31:0];
          busyLeft = W + 1;
        end
        5'h12: begin
          if (b == 32'h0) begin
            pendLo = 32'hFFFFFFFF; pendHi = a;
          end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            pendLo = 32'h80000000; pendHi = 32'h0;
          end else begin
            q = sa / sb; r = sa % sb; pendLo = 32'(q); pendHi = 32'(r);
          end
          busyLeft = W + 1;
        end
        5'h13: begin
          if (b == 32'h0) begin
            pendLo = 32'hFFFFFFFF; pendHi = a;
          end else begin
            pendLo = a / b; pendHi = a % b;
          end
          busyLeft = W + 1;
        end
        5'h16: mHi = a;
        5'h17: mLo = a;
        default: ;
      endcase
    end
  endfunction

  // One cycle of stimulus: drive, queue the expected response, advance the
  // model across the edge.
  task automatic applyStimulus(input logic v, input logic [4:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               output logic stalled);
    exp_t        e;
    logic [31:0] c;
    logic        ovf;
    A = a; B = b; ALUOp = op; OpValid = v;
    modelAlu(op, a, b, c, ovf);
    e.valid = v;
    e.op    = op;
    e.c     = c;
    e.zero  = (c == 32'h0);
    e.ovf   = ovf;
    e.busy  = (busyLeft > 0);
    e.stall = v && (busyLeft > 0) && (op >= 5'h10) && (op <= 5'h17);
    expQ.push_back(e);
    stalled = e.stall;
    @(posedge clk);
    modelEdge(v && !e.stall, op, a, b);
    #1;
  endtask

  // The pipeline holds a stalled instruction and re-presents it.
  task automatic issueOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic st;
    int   guard;
    guard = 0;
    do begin
      applyStimulus(1'b1, op, a, b, st);
      guard++;
    end while (st && guard < 40);
  endtask

  task automatic idleCycles(input int n);
    logic st;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'h00, 32'h0, 32'h0, st);
  endtask

  task automatic applyReset(input int n);
    rstn = 1'b0; OpValid = 1'b0; A = '0; B = '0; ALUOp = '0;
    repeat (n) @(posedge clk);
    mHi = '0; mLo = '0; busyLeft = 0;
    #1;
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return 32'(1 + $urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: every queued cycle is compared on the falling edge, away from
  // the active edge; the result fields only when an instruction is present.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (monActive && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("Busy", {31'b0, Busy}, {31'b0, e.busy});
      if (e.valid) begin
        checkOutput($sformatf("Stall op%02h", e.op), {31'b0, Stall}, {31'b0, e.stall});
        checkOutput($sformatf("C op%02h", e.op), C, e.c);
        checkOutput($sformatf("Zero op%02h", e.op), {31'b0, Zero}, {31'b0, e.zero});
        checkOutput($sformatf("Overflow op%02h", e.op), {31'b0, Overflow}, {31'b0, e.ovf});
      end
    end
  end

  // Main sequence: directed corner cases, overlap and mid-op reset, a
  // randomized run, then the 16-bit directed checks.
  initial begin
    logic        st;
    logic [4:0]  op;
    logic [31:0] ra, rb;
    int          pick, n;
    A = '0; B = '0; ALUOp = '0; OpValid = 1'b0;
    A16 = '0; B16 = '0; Op16 = '0; V16 = 1'b0;
    mHi = '0; mLo = '0; pendHi = '0; pendLo = '0; busyLeft = 0;
    rstn = 1'b0;
    $display("[TB] start");
    applyReset(2);
    monActive = 1'b1;

    issueOp(5'h00, 32'h0, 32'h0);
    issueOp(5'h01, 32'h7FFFFFFF, 32'h00000001);
    issueOp(5'h0B, 32'h00000024, 32'h80000000);

    issueOp(5'h10, 32'hFFFFFFFD, 32'h00000005);
    issueOp(5'h15, 32'h0, 32'h0);
    issueOp(5'h14, 32'h0, 32'h0);

    issueOp(5'h12, 32'hFFFFFFF9, 32'h00000002);
    issueOp(5'h15, 32'h0, 32'h0);
    issueOp(5'h14, 32'h0, 32'h0);
    issueOp(5'h13, 32'h00000007, 32'h00000000);
    issueOp(5'h15, 32'h0, 32'h0);
    issueOp(5'h14, 32'h0, 32'h0);
    issueOp(5'h12, 32'h80000000, 32'hFFFFFFFF);
    issueOp(5'h15, 32'h0, 32'h0);
    issueOp(5'h14, 32'h0, 32'h0);

    issueOp(5'h11, 32'h12345678, 32'h9ABCDEF0);
    issueOp(5'h13, 32'hDEADBEEF, 32'h00001234);
    issueOp(5'h15, 32'h0, 32'h0);
    issueOp(5'h14, 32'h0, 32'h0);
    issueOp(5'h16, 32'hCAFEF00D, 32'h0);
    issueOp(5'h17, 32'h0BADF00D, 32'h0);
    issueOp(5'h14, 32'h0, 32'h0);
    issueOp(5'h15, 32'h0, 32'h0);

    issueOp(5'h11, 32'h12345678, 32'h9ABCDEF0);
    issueOp(5'h01, 32'h80000000, 32'h80000000);
    issueOp(5'h02, 32'h80000000, 32'h00000001);
    issueOp(5'h08, 32'h0, 32'h0000BEEF);
    idleCycles(6);
    applyReset(1);
    issueOp(5'h14, 32'h0, 32'h0);
    issueOp(5'h15, 32'h0, 32'h0);

    for (int i = 0; i < 500; i++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 10)      op = 5'h10 + 5'($urandom_range(0, 3));
      else if (pick < 22) op = 5'h14 + 5'($urandom_range(0, 3));
      else if (pick < 27) op = badOps[$urandom_range(0, 4)];
      else                op = 5'($urandom_range(0, 12));
      ra = randOperand();
      rb = randOperand();
      if ($urandom_range(0, 9) < 8) issueOp(op, ra, rb);
      else applyStimulus(1'b0, op, ra, rb, st);
    end
    idleCycles(40);
    monActive = 1'b0;

    A16 = 16'hFFFF; B16 = 16'hFFFF; Op16 = 5'h11; V16 = 1'b1;
    @(posedge clk); #1;
    V16 = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Busy16) n++;
      else break;
    end
    checkOutput("w16 busy cycles", 32'(n), 32'd17);
    Op16 = 5'h14; V16 = 1'b1; #1;
    checkOutput("w16 MFHI", {16'h0, C16}, 32'h0000FFFE);
    Op16 = 5'h15; #1;
    checkOutput("w16 MFLO", {16'h0, C16}, 32'h00000001);
    Op16 = 5'h08; B16 = 16'h00AB; #1;
    checkOutput("w16 LUI", {16'h0, C16}, 32'h0000AB00);
    checkOutput("w16 LUI Zero", {31'b0, Zero16}, 32'd0);
    checkOutput("w16 LUI Overflow", {31'b0, Overflow16}, 32'd0);
    checkOutput("w16 LUI Stall", {31'b0, Stall16}, 32'd0);
    V16 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
